bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 63: number of ce-qualified cycles a bus cycle or a DMA grant may wait for a response before it is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port ce, input, 1 bit: clock enable; when 0, all state, counters and outputs hold.
REQ-005 SHALL have port cpu_dati, input, 1 bit: CPU read-cycle request, a level held until cpu_done or cpu_error.
REQ-006 SHALL have port cpu_dato, input, 1 bit: CPU write-cycle request, a level held until cpu_done or cpu_error.
REQ-007 SHALL have port cpu_byte, input, 1 bit: the requested cycle is a byte access.
REQ-008 SHALL have port rply, input, 1 bit: slave reply.
REQ-009 SHALL have port data_i, input, 16 bits: bus read data.
REQ-010 SHALL have port dmr, input, 1 bit: DMA request.
REQ-011 SHALL have port sack, input, 1 bit: DMA master active.
REQ-012 SHALL have ports sync, din, dout and wtbt, each an output of 1 bit: registered bus strobes.
REQ-013 SHALL have port dmgo, output, 1 bit: DMA grant offer.
REQ-014 SHALL have port cpu_done, output, 1 bit: one-cycle pulse on successful cycle completion.
REQ-015 SHALL have port cpu_error, output, 1 bit: one-cycle pulse on bus timeout.
REQ-016 SHALL have port rdata_o, output, 16 bits: read data latched on reply.
REQ-017 SHALL have port bsy, output, 1 bit: equal to sync.

Function
REQ-018 SHALL implement the states IDLE, RD, WR, GAP, ERR, GRANT and DMA; every state, counter and output advances only when ce=1.
REQ-019 SHALL, in IDLE, select the next state by priority: dmr=1 gives GRANT; otherwise cpu_dati=1 gives RD; otherwise cpu_dato=1 gives WR.
REQ-020 SHALL give DMA priority when dmr and a CPU request arrive in the same cycle; the CPU request stays pending and is served after DMA releases the bus.
REQ-021 SHALL treat cpu_dati and cpu_dato both asserted as a read.
REQ-022 SHALL, on entry to RD or WR, latch wtbt=cpu_byte and load the timeout counter (6-bit minimum) with BUS_TIMEOUT.
REQ-023 SHALL set sync=din=1 in RD and sync=dout=1 in WR, starting the first cycle after the request is sampled (1-cycle latency).
REQ-024 SHALL, in RD or WR with rply=1, complete the cycle on the next edge: go to GAP, drop sync, din, dout and wtbt, and pulse cpu_done for 1 cycle.
REQ-025 SHALL, in RD with rply=1, capture data_i into rdata_o; rdata_o holds until the next successful read.
REQ-026 SHALL, in RD or WR with rply=0, decrement the counter by 1 each cycle; when the counter is 0 and rply=0, go to ERR.
REQ-027 SHALL let rply win when rply=1 arrives in the same cycle the counter reaches 0.
REQ-028 SHALL, in ERR, drop all strobes, pulse cpu_error for 1 cycle, leave rdata_o unchanged, and go to GAP.
REQ-029 SHALL hold GAP for exactly 1 cycle with all strobes low, then go to IDLE, guaranteeing at least 1 idle cycle between back-to-back cycles.
REQ-030 SHALL, in GRANT, set dmgo=1 and load the counter with BUS_TIMEOUT on entry.
REQ-031 SHALL, in GRANT, go to DMA when sack=1; go to IDLE when dmr=0 and sack=0; go to IDLE when the counter is 0 and sack=0.
REQ-032 SHALL, in DMA, set dmgo=0 and all strobes 0, and stay in DMA while sack=1; sack=0 goes to IDLE.
REQ-033 SHALL never raise any CPU strobe while in GRANT or DMA.
REQ-034 SHALL never assert din and dout together.
REQ-035 SHALL never pulse cpu_done and cpu_error in the same cycle.
REQ-036 SHALL ignore rply in IDLE, GAP, GRANT and DMA.

Reset
REQ-037 SHALL, when reset=1 at a clk edge, regardless of ce, force state IDLE, counter = BUS_TIMEOUT, rdata_o = 0, and sync, din, dout, wtbt, dmgo, cpu_done and cpu_error all 0.
REQ-038 SHALL, when reset is asserted mid-cycle or mid-grant, drop all strobes and dmgo on the next edge without pulsing cpu_done or cpu_error.

Verification
REQ-039 SHALL cover a read: cpu_dati=1, rply after 3 cycles with data_i=0o177716 -> sync/din high 4 cycles, cpu_done 1 pulse, rdata_o=0o177716, 1 GAP cycle.
REQ-040 SHALL cover a byte write: cpu_dato=1, cpu_byte=1, rply after 2 cycles -> dout=wtbt=1 for 3 cycles, din stays 0, cpu_done pulses.
REQ-041 SHALL cover a timeout: cpu_dati=1, rply never asserted, BUS_TIMEOUT=63 -> sync high for 64 cycles, cpu_error 1 pulse, rdata_o unchanged.
REQ-042 SHALL cover simultaneous requests: dmr and cpu_dato rise in the same cycle -> dmgo=1, sync=0; then sack=1 for 5 cycles, then sack=0 -> IDLE, then WR starts the next cycle.
REQ-043 SHALL cover grant withdrawal: dmr=1 for 3 cycles with no sack -> dmgo high 3 cycles then 0, state IDLE, no strobes.
REQ-044 SHALL cover ce and reset: ce=0 during RD holds sync and the counter frozen; reset=1 mid-RD -> all outputs 0 next edge, no cpu_done.

Source files
------------

// File: rtl/bus_arbiter.sv
// Single-master bus cycle sequencer with DMA grant arbitration and reply timeout.
// Strobes, pulses and read data are all registered and advance only when ce=1.
module bus_arbiter #(
   parameter int BUS_TIMEOUT = 63
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        cpu_dati,
   input  logic        cpu_dato,
   input  logic        cpu_byte,
   input  logic        rply,
   input  logic [15:0] data_i,
   input  logic        dmr,
   input  logic        sack,
   output logic        sync,
   output logic        din,
   output logic        dout,
   output logic        wtbt,
   output logic        dmgo,
   output logic        cpu_done,
   output logic        cpu_error,
   output logic [15:0] rdata_o,
   output logic        bsy
);

   localparam int CW = (BUS_TIMEOUT < 64) ? 6 : $clog2(BUS_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(BUS_TIMEOUT);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD    = 3'd1;
   localparam logic [2:0] S_WR    = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;
   localparam logic [2:0] S_GRANT = 3'd5;
   localparam logic [2:0] S_DMA   = 3'd6;

   logic [2:0]    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          sync_reg, sync_next;
   logic          din_reg, din_next;
   logic          dout_reg, dout_next;
   logic          wtbt_reg, wtbt_next;
   logic          dmgo_reg, dmgo_next;
   logic          done_reg, done_next;
   logic          error_reg, error_next;
   logic [15:0]   rdata_reg, rdata_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sync_next  = 1'b0;
      din_next   = 1'b0;
      dout_next  = 1'b0;
      wtbt_next  = 1'b0;
      dmgo_next  = 1'b0;
      done_next  = 1'b0;
      error_next = 1'b0;
      rdata_next = rdata_reg;
      case (state_reg)
         S_IDLE: begin
            // DMA wins over a simultaneous CPU request; the CPU level stays pending.
            if (dmr) begin
               state_next = S_GRANT;
               cnt_next   = CNT_LOAD;
               dmgo_next  = 1'b1;
            end else if (cpu_dati || cpu_dato) begin
               state_next = cpu_dati ? S_RD : S_WR;
               cnt_next   = CNT_LOAD;
               sync_next  = 1'b1;
               din_next   = cpu_dati;
               dout_next  = !cpu_dati;
               wtbt_next  = cpu_byte;
            end
         end
         S_RD, S_WR: begin
            // A reply on the last counted cycle still completes the transfer.
            if (rply) begin
               state_next = S_GAP;
               done_next  = 1'b1;
               if (state_reg == S_RD) begin
                  rdata_next = data_i;
               end
            end else if (cnt_reg == '0) begin
               state_next = S_ERR;
               error_next = 1'b1;
            end else begin
               cnt_next  = cnt_reg - 1'b1;
               sync_next = 1'b1;
               din_next  = (state_reg == S_RD);
               dout_next = (state_reg == S_WR);
               wtbt_next = wtbt_reg;
            end
         end
         S_ERR:   state_next = S_GAP;
         S_GAP:   state_next = S_IDLE;
         S_GRANT: begin
            if (sack) begin
               state_next = S_DMA;
            end else if (!dmr || cnt_reg == '0) begin
               state_next = S_IDLE;
            end else begin
               cnt_next  = cnt_reg - 1'b1;
               dmgo_next = 1'b1;
            end
         end
         S_DMA: begin
            if (!sack) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= CNT_LOAD;
         sync_reg  <= 1'b0;
         din_reg   <= 1'b0;
         dout_reg  <= 1'b0;
         wtbt_reg  <= 1'b0;
         dmgo_reg  <= 1'b0;
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         rdata_reg <= 16'h0000;
      end else if (ce) begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         sync_reg  <= sync_next;
         din_reg   <= din_next;
         dout_reg  <= dout_next;
         wtbt_reg  <= wtbt_next;
         dmgo_reg  <= dmgo_next;
         done_reg  <= done_next;
         error_reg <= error_next;
         rdata_reg <= rdata_next;
      end
   end

   assign sync      = sync_reg;
   assign din       = din_reg;
   assign dout      = dout_reg;
   assign wtbt      = wtbt_reg;
   assign dmgo      = dmgo_reg;
   assign cpu_done  = done_reg;
   assign cpu_error = error_reg;
   assign rdata_o   = rdata_reg;
   assign bsy       = sync_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a transaction-level model checked every cycle,
// plus hand-computed cycle counts for each scenario.
module tb_bus_arbiter;

   localparam int TMO = 63;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b1;
   logic        cpu_dati = 1'b0;
   logic        cpu_dato = 1'b0;
   logic        cpu_byte = 1'b0;
   logic        rply = 1'b0;
   logic [15:0] data_i = 16'h0000;
   logic        dmr = 1'b0;
   logic        sack = 1'b0;
   logic        sync, din, dout, wtbt, dmgo, cpu_done, cpu_error, bsy;
   logic [15:0] rdata_o;

   always #5 clk = ~clk;

   bus_arbiter #(.BUS_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .ce(ce), .cpu_dati(cpu_dati), .cpu_dato(cpu_dato),
      .cpu_byte(cpu_byte), .rply(rply), .data_i(data_i), .dmr(dmr), .sack(sack),
      .sync(sync), .din(din), .dout(dout), .wtbt(wtbt), .dmgo(dmgo),
      .cpu_done(cpu_done), .cpu_error(cpu_error), .rdata_o(rdata_o), .bsy(bsy)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: what the bus owner is doing, how long it has waited, and a queue
   // of the output frames still owed after a transfer ends.
   localparam int A_IDLE = 0, A_READ = 1, A_WRITE = 2, A_OFFER = 3, A_DMA = 4, A_TAIL = 5;
   localparam int T_DONE = 1, T_ERR = 2, T_QUIET = 3;
   int          m_act = A_IDLE;
   int          m_age = 0;
   bit          m_byte = 1'b0;
   logic [15:0] m_rdata = 16'h0000;
   int          tail[$];

   always @(posedge clk) begin
      if (reset) begin
         m_act = A_IDLE; m_age = 0; m_byte = 1'b0; m_rdata = 16'h0000; tail.delete();
      end else if (ce) begin
         case (m_act)
            A_IDLE: begin
               if (dmr) begin
                  m_act = A_OFFER; m_age = 0;
               end else if (cpu_dati || cpu_dato) begin
                  m_act = cpu_dati ? A_READ : A_WRITE; m_age = 0; m_byte = cpu_byte;
               end
            end
            A_READ, A_WRITE: begin
               if (rply) begin
                  if (m_act == A_READ) m_rdata = data_i;
                  tail = '{T_DONE}; m_act = A_TAIL;
               end else if (m_age == TMO) begin
                  tail = '{T_ERR, T_QUIET}; m_act = A_TAIL;
               end else m_age++;
            end
            A_TAIL: begin
               void'(tail.pop_front());
               if (tail.size() == 0) m_act = A_IDLE;
            end
            A_OFFER: begin
               if (sack) m_act = A_DMA;
               else if (!dmr || m_age == TMO) m_act = A_IDLE;
               else m_age++;
            end
            A_DMA: if (!sack) m_act = A_IDLE;
            default: m_act = A_IDLE;
         endcase
      end
   end

   int n_sync = 0, n_din = 0, n_dout = 0, n_wtbt = 0, n_dmgo = 0, n_done = 0, n_err = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         bit busy, e_done, e_err;
         busy   = (m_act == A_READ) || (m_act == A_WRITE);
         e_done = (m_act == A_TAIL) && (tail.size() > 0) && (tail[0] == T_DONE);
         e_err  = (m_act == A_TAIL) && (tail.size() > 0) && (tail[0] == T_ERR);
         check("sync", 32'(sync), 32'(busy));
         check("bsy", 32'(bsy), 32'(busy));
         check("din", 32'(din), 32'(m_act == A_READ));
         check("dout", 32'(dout), 32'(m_act == A_WRITE));
         check("wtbt", 32'(wtbt), 32'(busy && m_byte));
         check("dmgo", 32'(dmgo), 32'(m_act == A_OFFER));
         check("cpu_done", 32'(cpu_done), 32'(e_done));
         check("cpu_error", 32'(cpu_error), 32'(e_err));
         check("rdata_o", 32'(rdata_o), 32'(m_rdata));
         check("din_dout_excl", 32'(din & dout), 32'd0);
         check("done_err_excl", 32'(cpu_done & cpu_error), 32'd0);
         if (sync) n_sync++;
         if (din) n_din++;
         if (dout) n_dout++;
         if (wtbt) n_wtbt++;
         if (dmgo) n_dmgo++;
         if (cpu_done) n_done++;
         if (cpu_error) n_err++;
      end
   end

   int s_sync, s_din, s_dout, s_wtbt, s_dmgo, s_done, s_err;

   task automatic snap();
      s_sync = n_sync; s_din = n_din; s_dout = n_dout; s_wtbt = n_wtbt;
      s_dmgo = n_dmgo; s_done = n_done; s_err = n_err;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic bit cond(input int which);
      case (which)
         0: return sync;
         1: return cpu_done | cpu_error;
         2: return dmgo;
         default: return cpu_error;
      endcase
   endfunction

   task automatic wait_cond(input int which, input int limit, input string name);
      int n = 0;
      while (!cond(which) && n < limit) begin
         step();
         n++;
      end
      check(name, 32'(cond(which)), 32'd1);
   endtask

   // One CPU transfer; delay is the count of reply-less cycles after the first
   // strobed cycle, or -1 for no reply at all.
   task automatic run_bus(input bit rq_rd, input bit rq_wr, input bit byt,
                          input int delay, input logic [15:0] d);
      cpu_dati = rq_rd; cpu_dato = rq_wr; cpu_byte = byt; data_i = d;
      wait_cond(0, 10, "wait_sync");
      if (delay >= 0) begin
         repeat (delay) step();
         rply = 1'b1;
      end
      wait_cond(1, 200, "wait_end");
      cpu_dati = 1'b0; cpu_dato = 1'b0; cpu_byte = 1'b0; rply = 1'b0;
      step();
      step();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      step();
      chk_en = 1'b1;
      check("rst_sync", 32'(sync), 32'd0);
      check("rst_dmgo", 32'(dmgo), 32'd0);
      check("rst_rdata", 32'(rdata_o), 32'd0);
      reset = 1'b0;
      step();

      snap();
      run_bus(1'b1, 1'b0, 1'b0, 3, 16'o177716);
      check("rd_sync_cycles", n_sync - s_sync, 4);
      check("rd_din_cycles", n_din - s_din, 4);
      check("rd_done_pulses", n_done - s_done, 1);
      check("rd_data", 32'(rdata_o), 32'o177716);

      snap();
      run_bus(1'b0, 1'b1, 1'b1, 2, 16'h5555);
      check("wrb_dout_cycles", n_dout - s_dout, 3);
      check("wrb_wtbt_cycles", n_wtbt - s_wtbt, 3);
      check("wrb_din_cycles", n_din - s_din, 0);
      check("wrb_done_pulses", n_done - s_done, 1);

      snap();
      run_bus(1'b1, 1'b0, 1'b0, -1, 16'h0F0F);
      check("tmo_sync_cycles", n_sync - s_sync, 64);
      check("tmo_err_pulses", n_err - s_err, 1);
      check("tmo_done_pulses", n_done - s_done, 0);
      check("tmo_rdata_kept", 32'(rdata_o), 32'o177716);

      snap();
      run_bus(1'b1, 1'b1, 1'b0, 0, 16'h1234);
      check("both_din_cycles", n_din - s_din, 1);
      check("both_dout_cycles", n_dout - s_dout, 0);
      check("both_rdata", 32'(rdata_o), 32'h1234);

      snap();
      run_bus(1'b1, 1'b0, 1'b0, 63, 16'hBEEF);
      check("edge_sync_cycles", n_sync - s_sync, 64);
      check("edge_done_pulses", n_done - s_done, 1);
      check("edge_err_pulses", n_err - s_err, 0);

      dmr = 1'b1; cpu_dato = 1'b1;
      step();
      check("sim_dmgo", 32'(dmgo), 32'd1);
      check("sim_sync", 32'(sync), 32'd0);
      sack = 1'b1; dmr = 1'b0;
      repeat (5) step();
      check("sim_dma_dmgo", 32'(dmgo), 32'd0);
      sack = 1'b0;
      step();
      check("sim_idle_sync", 32'(sync), 32'd0);
      step();
      check("sim_wr_sync", 32'(sync), 32'd1);
      check("sim_wr_dout", 32'(dout), 32'd1);
      rply = 1'b1;
      wait_cond(1, 10, "sim_wait_end");
      cpu_dato = 1'b0; rply = 1'b0;
      step(); step();

      snap();
      dmr = 1'b1;
      repeat (3) step();
      dmr = 1'b0;
      step(); step();
      check("wd_dmgo_cycles", n_dmgo - s_dmgo, 3);
      check("wd_sync_cycles", n_sync - s_sync, 0);

      snap();
      dmr = 1'b1;
      repeat (70) step();
      dmr = 1'b0;
      step(); step();
      check("gtmo_dmgo_cycles", n_dmgo - s_dmgo, 69);

      snap();
      cpu_dati = 1'b1;
      wait_cond(0, 10, "ce_wait_sync");
      repeat (10) step();
      ce = 1'b0;
      repeat (20) step();
      check("ce_hold_sync", 32'(sync), 32'd1);
      ce = 1'b1;
      wait_cond(3, 200, "ce_wait_err");
      cpu_dati = 1'b0;
      step(); step();
      check("ce_sync_cycles", n_sync - s_sync, 84);
      check("ce_err_pulses", n_err - s_err, 1);

      snap();
      cpu_dati = 1'b1; rply = 1'b0;
      wait_cond(0, 10, "rst_wait_sync");
      step(); step();
      reset = 1'b1; ce = 1'b0;
      step();
      check("rrd_sync", 32'(sync), 32'd0);
      check("rrd_din", 32'(din), 32'd0);
      check("rrd_rdata", 32'(rdata_o), 32'd0);
      reset = 1'b0; ce = 1'b1; cpu_dati = 1'b0;
      step(); step();
      check("rrd_done_pulses", n_done - s_done, 0);
      check("rrd_err_pulses", n_err - s_err, 0);

      dmr = 1'b1;
      wait_cond(2, 10, "rgr_wait_dmgo");
      reset = 1'b1;
      step();
      check("rgr_dmgo", 32'(dmgo), 32'd0);
      reset = 1'b0; dmr = 1'b0;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "simulation watchdog expired");
   end

endmodule
